biquad8_coeff_loader: RTL and testbench

- WISHBONE master that copies a pre-stored coefficient program from a local synchronous memory into one of up to 2**TGT_BITS biquad8 filter slots.
- Each program entry is replayed as one single write. An optional write of 1 to offset 0x00 then triggers the coefficient update.
- Sits between the control/host logic and the WISHBONE interconnect of the filter bank, so software issues one start command instead of a long run of writes.

---
 rtl/biquad8_coeff_loader_pkg.sv | 31 +++
 rtl/biquad8_coeff_loader_if.sv | 24 ++
 rtl/biquad8_coeff_loader.sv | 185 ++++++++++++++++++
 tb/tb_biquad8_coeff_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/biquad8_coeff_loader_pkg.sv
// Shared types and constants for the biquad8 coefficient loader:
// FSM states, program-word field positions and filter register offsets.
package biquad8_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WRITE,
        S_UPD,
        S_DONE,
        S_ERR
    } state_e;

    localparam int unsigned LAST_BIT   = 31;
    localparam int unsigned OFFSET_MSB = 30;
    localparam int unsigned OFFSET_LSB = 24;
    localparam int unsigned COEFF_BITS = 18;

    localparam logic [6:0] REG_UPDATE        = 7'h00;
    localparam logic [6:0] REG_FIR           = 7'h04;
    localparam logic [6:0] REG_IIR           = 7'h08;
    localparam logic [6:0] REG_INC           = 7'h0C;
    localparam logic [6:0] REG_POLEFIR_FIRST = 7'h10;
    localparam logic [6:0] REG_POLEFIR_LAST  = 7'h1C;

    function automatic logic [31:0] pack_coeff(input logic [COEFF_BITS-1:0] c);
        return {{(32-COEFF_BITS){1'b0}}, c};
    endfunction

endpackage

// File: rtl/biquad8_coeff_loader_if.sv
// WISHBONE master-side bus bundle between the loader and the filter bank interconnect.
interface biquad8_coeff_loader_if #(
    parameter int unsigned TGT_BITS = 4
);
    logic                  wbm_cyc_o;
    logic                  wbm_stb_o;
    logic                  wbm_we_o;
    logic [TGT_BITS+6:0]   wbm_adr_o;
    logic [31:0]           wbm_dat_o;
    logic [3:0]            wbm_sel_o;
    logic                  wbm_ack_i;
    logic                  wbm_err_i;
    logic                  wbm_rty_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        input  wbm_ack_i, wbm_err_i, wbm_rty_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        output wbm_ack_i, wbm_err_i, wbm_rty_i
    );
endinterface

// File: rtl/biquad8_coeff_loader.sv
// Replays a coefficient program from local memory as single WISHBONE writes
// into one biquad8 slot, optionally followed by an update-trigger write.
module biquad8_coeff_loader
    import biquad8_loader_pkg::*;
#(
    parameter int unsigned TGT_BITS      = 4,
    parameter int unsigned MEM_ADDR_BITS = 8,
    parameter int unsigned TIMEOUT       = 255,
    parameter int unsigned MAX_WORDS     = 64
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     start_i,
    input  logic [TGT_BITS-1:0]      target_i,
    input  logic [MEM_ADDR_BITS-1:0] prog_base_i,
    input  logic                     do_update_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic                     mem_en_o,
    output logic [MEM_ADDR_BITS-1:0] mem_addr_o,
    input  logic [31:0]              mem_dat_i,
    biquad8_coeff_loader_if.master   wbm
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WORDS);

    state_e                   state_q, state_d;
    logic [TGT_BITS-1:0]      tgt_q, tgt_d;
    logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic                     upd_q, upd_d;
    logic                     last_q, last_d;
    logic [4:0]               off_q, off_d;
    logic [COEFF_BITS-1:0]    coeff_q, coeff_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic                     hold_q, hold_d;
    logic                     err_q, err_d;

    logic                     cyc, stb, we;
    logic [TGT_BITS+6:0]      adr;
    logic [31:0]              dat;

    // Offset bits [1:0] and the gap between offset and coefficient are don't-care.
    logic unused_bits;
    assign unused_bits = ^{mem_dat_i[OFFSET_LSB+1:OFFSET_LSB], mem_dat_i[OFFSET_LSB-1:COEFF_BITS]};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
            addr_q  <= '0;
            upd_q   <= 1'b0;
            last_q  <= 1'b0;
            off_q   <= '0;
            coeff_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            hold_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            addr_q  <= addr_d;
            upd_q   <= upd_d;
            last_q  <= last_d;
            off_q   <= off_d;
            coeff_q <= coeff_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        addr_d     = addr_q;
        upd_d      = upd_q;
        last_d     = last_q;
        off_d      = off_q;
        coeff_d    = coeff_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        hold_d     = hold_q;
        err_d      = err_q;
        mem_en_o   = 1'b0;
        mem_addr_o = '0;
        done_o     = 1'b0;
        cyc        = 1'b0;
        stb        = 1'b0;
        we         = 1'b0;
        adr        = '0;
        dat        = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    tgt_d   = target_i;
                    addr_d  = prog_base_i;
                    upd_d   = do_update_i;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_en_o   = 1'b1;
                mem_addr_o = addr_q;
                state_d    = S_LATCH;
            end
            S_LATCH: begin
                last_d  = mem_dat_i[LAST_BIT];
                off_d   = mem_dat_i[OFFSET_MSB:OFFSET_LSB+2];
                coeff_d = mem_dat_i[COEFF_BITS-1:0];
                cnt_d   = cnt_q + 1'b1;
                tmo_d   = '0;
                hold_d  = 1'b0;
                state_d = S_WRITE;
            end
            S_WRITE, S_UPD: begin
                cyc = 1'b1;
                we  = 1'b1;
                stb = !hold_q;
                if (state_q == S_UPD) begin
                    adr = {tgt_q, REG_UPDATE};
                    dat = 32'h1;
                end else begin
                    adr = {tgt_q, off_q, 2'b00};
                    dat = pack_coeff(coeff_q);
                end
                tmo_d  = tmo_q + 1'b1;
                hold_d = 1'b0;
                // Responses are ignored during the retry gap; the timeout keeps running.
                if (!hold_q && wbm.wbm_err_i) begin
                    state_d = S_ERR;
                end else if (!hold_q && wbm.wbm_ack_i) begin
                    tmo_d = '0;
                    if (state_q == S_UPD) begin
                        state_d = S_DONE;
                    end else if (last_q) begin
                        state_d = upd_q ? S_UPD : S_DONE;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = S_ERR;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                end else if (!hold_q && wbm.wbm_rty_i) begin
                    hold_d = 1'b1;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_ERR) begin
            err_d = 1'b1;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign err_o         = err_q;
    assign wbm.wbm_cyc_o = cyc;
    assign wbm.wbm_stb_o = stb;
    assign wbm.wbm_we_o  = we;
    assign wbm.wbm_adr_o = adr;
    assign wbm.wbm_dat_o = dat;
    assign wbm.wbm_sel_o = 4'hF;

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Directed bench for biquad8_coeff_loader: memory model, scripted WISHBONE slave,
// hand-computed expected write traces.
module tb_biquad8_coeff_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  tgt;
    logic [7:0]  base;
    logic        upd;
    logic        busy, done, err, mem_en;
    logic [7:0]  mem_addr;
    logic [31:0] mem_q;
    logic [31:0] mem [256];

    biquad8_coeff_loader_if #(.TGT_BITS(4)) wb ();

    biquad8_coeff_loader #(
        .TGT_BITS(4), .MEM_ADDR_BITS(8), .TIMEOUT(255), .MAX_WORDS(64)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .target_i(tgt),
        .prog_base_i(base), .do_update_i(upd), .busy_o(busy), .done_o(done),
        .err_o(err), .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_dat_i(mem_q),
        .wbm(wb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_en) mem_q <= mem[mem_addr];

    int n_checks = 0;
    int n_pass   = 0;

    // Slave behaviour knobs; -1 disables a fault.
    int ack_delay = 2;
    int err_idx   = -1;
    int noack_idx = -1;
    int rty_idx   = -1;

    int          rty_done, resp_idx, wcnt;
    int          n_wr, n_att, gap_cnt, done_cnt, rd_cnt, bus_bad;
    int          cur_run, last_run, cyc_fall_at, busy_fall_at, cyc_n;
    logic        prev_cyc = 1'b0, prev_busy = 1'b0;
    logic [10:0] wr_adr [128];
    logic [31:0] wr_dat [128];
    logic [10:0] att_adr [8];
    logic [31:0] att_dat [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic clear_stats();
        rty_done = 0; resp_idx = 0; wcnt = 0; n_wr = 0; n_att = 0; gap_cnt = 0;
        done_cnt = 0; rd_cnt = 0; bus_bad = 0; cur_run = 0; last_run = 0;
        cyc_fall_at = 0; busy_fall_at = 0;
    endtask

    task automatic kick(input logic [3:0] t, input logic [7:0] b, input logic u);
        @(posedge clk); #1;
        clear_stats();
        tgt = t; base = b; upd = u; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; tgt = ~t; base = ~b; upd = ~u;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("idle_in_budget", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    // Slave and monitor: sample at negedge, present responses for the next posedge.
    initial begin
        wb.wbm_ack_i = 1'b0; wb.wbm_err_i = 1'b0; wb.wbm_rty_i = 1'b0;
        clear_stats();
        cyc_n = 0;
        forever begin
            @(negedge clk);
            cyc_n++;
            wb.wbm_ack_i = 1'b0; wb.wbm_err_i = 1'b0; wb.wbm_rty_i = 1'b0;
            if (done)   done_cnt++;
            if (mem_en) rd_cnt++;
            if (wb.wbm_cyc_o) cur_run++;
            else if (cur_run != 0) begin last_run = cur_run; cur_run = 0; end
            if (prev_cyc && !wb.wbm_cyc_o) cyc_fall_at = cyc_n;
            if (prev_busy && !busy) busy_fall_at = cyc_n;
            prev_cyc = wb.wbm_cyc_o;
            prev_busy = busy;
            if (wb.wbm_cyc_o && wb.wbm_stb_o) begin
                if (!wb.wbm_we_o || wb.wbm_sel_o != 4'hF) bus_bad++;
                if (wcnt == 0 && n_att < 8) begin
                    att_adr[n_att] = wb.wbm_adr_o;
                    att_dat[n_att] = wb.wbm_dat_o;
                    n_att++;
                end
                wcnt++;
                if (wcnt >= ack_delay) begin
                    if (resp_idx == err_idx) begin
                        wb.wbm_err_i = 1'b1;
                        resp_idx++;
                    end else if (resp_idx == noack_idx) begin
                        wb.wbm_ack_i = 1'b0;
                    end else if (resp_idx == rty_idx && rty_done == 0) begin
                        wb.wbm_rty_i = 1'b1;
                        rty_done = 1;
                    end else begin
                        wb.wbm_ack_i = 1'b1;
                        if (n_wr < 128) begin
                            wr_adr[n_wr] = wb.wbm_adr_o;
                            wr_dat[n_wr] = wb.wbm_dat_o;
                        end
                        n_wr++;
                        resp_idx++;
                    end
                end
            end else begin
                wcnt = 0;
                if (wb.wbm_cyc_o) gap_cnt++;
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; tgt = '0; base = '0; upd = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        // Entry 2 carries offset 0x0B and junk in [23:18] to exercise masking.
        mem[8'h10] = 32'h0401FFFF;
        mem[8'h11] = 32'h0BFC0123;
        mem[8'h12] = 32'h9C03FFFF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", 32'({busy, done, err, mem_en, wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o}), 32'd0);
        chk("rst_adr", 32'(wb.wbm_adr_o), 32'd0);
        chk("rst_dat", wb.wbm_dat_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 3 words plus update write; target_i changes after start.
        kick(4'd5, 8'h10, 1'b1);
        wait_idle(2000);
        chk("t1_nwr", 32'(n_wr), 32'd4);
        chk("t1_adr0", 32'(wr_adr[0]), 32'h284);
        chk("t1_dat0", wr_dat[0], 32'h0001FFFF);
        chk("t1_adr1", 32'(wr_adr[1]), 32'h288);
        chk("t1_dat1", wr_dat[1], 32'h00000123);
        chk("t1_adr2", 32'(wr_adr[2]), 32'h29C);
        chk("t1_dat2", wr_dat[2], 32'h0003FFFF);
        chk("t1_adr3", 32'(wr_adr[3]), 32'h280);
        chk("t1_dat3", wr_dat[3], 32'h00000001);
        chk("t1_done", 32'(done_cnt), 32'd1);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_reads", 32'(rd_cnt), 32'd3);
        chk("t1_bus", 32'(bus_bad), 32'd0);

        // No update write.
        kick(4'd5, 8'h10, 1'b0);
        wait_idle(2000);
        chk("t2_nwr", 32'(n_wr), 32'd3);
        chk("t2_last_adr", 32'(wr_adr[2]), 32'h29C);
        chk("t2_done", 32'(done_cnt), 32'd1);

        // Second write never acknowledged.
        noack_idx = 1;
        kick(4'd5, 8'h10, 1'b1);
        wait_idle(2000);
        noack_idx = -1;
        chk("t3_cyc_len", 32'(last_run), 32'd255);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_done", 32'(done_cnt), 32'd0);
        chk("t3_busy_lag", 32'(busy_fall_at - cyc_fall_at), 32'd1);
        chk("t3_nwr", 32'(n_wr), 32'd1);

        // Slave error on first write, then a clean rerun.
        err_idx = 0;
        kick(4'd5, 8'h10, 1'b1);
        wait_idle(2000);
        err_idx = -1;
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_reads", 32'(rd_cnt), 32'd1);
        chk("t4_nwr", 32'(n_wr), 32'd0);
        kick(4'd5, 8'h10, 1'b1);
        chk("t4_err_clr", 32'(err), 32'd0);
        wait_idle(2000);
        chk("t4_rerun_nwr", 32'(n_wr), 32'd4);
        chk("t4_rerun_done", 32'(done_cnt), 32'd1);
        chk("t4_rerun_err", 32'(err), 32'd0);

        // One retry on the first write.
        rty_idx = 0;
        kick(4'd5, 8'h10, 1'b0);
        wait_idle(2000);
        rty_idx = -1;
        chk("t5_natt", 32'(n_att), 32'd4);
        chk("t5_re_adr", 32'(att_adr[1]), 32'h284);
        chk("t5_re_dat", att_dat[1], 32'h0001FFFF);
        chk("t5_gap", 32'(gap_cnt), 32'd1);
        chk("t5_nwr", 32'(n_wr), 32'd3);
        chk("t5_done", 32'(done_cnt), 32'd1);

        // Reset while a write is on the bus.
        begin
            int k = 0;
            kick(4'd5, 8'h10, 1'b1);
            while (!wb.wbm_cyc_o && k < 50) begin
                @(negedge clk);
                k++;
            end
            chk("t7_cyc_seen", 32'(wb.wbm_cyc_o), 32'd1);
            rst = 1'b1;
            @(negedge clk);
            chk("t7_ctl", 32'({busy, done, err, mem_en, wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o}), 32'd0);
            chk("t7_adr", 32'(wb.wbm_adr_o), 32'd0);
            chk("t7_dat", wb.wbm_dat_o, 32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            repeat (20) @(posedge clk);
            #1;
            chk("t7_nwr", 32'(n_wr), 32'd0);
            chk("t7_reads", 32'(rd_cnt), 32'd1);
        end

        // 64 words without a last flag, wrapping past 0xFF, with a stray start mid-run.
        for (int i = 0; i < 64; i++) mem[8'(8'hF0 + i)] = {1'b0, 7'h04, 6'h00, 18'(i)};
        kick(4'd5, 8'hF0, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        start = 1'b1; tgt = 4'd3; base = 8'h10; upd = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(2000);
        chk("t6_nwr", 32'(n_wr), 32'd64);
        chk("t6_err", 32'(err), 32'd1);
        chk("t6_done", 32'(done_cnt), 32'd0);
        chk("t6_reads", 32'(rd_cnt), 32'd64);
        chk("t6_wrap_dat", wr_dat[16], 32'd16);
        chk("t6_last_dat", wr_dat[63], 32'd63);
        chk("t6_tgt_adr", 32'(wr_adr[40]), 32'h284);
        chk("t6_bus", 32'(bus_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
